if_id_elastic_stage: RTL and testbench

Parametrised successor to the fixed IF/ID register. It is a 2-entry elastic pipeline stage between fetch and decode that carries {pc, instr} under a valid/ready handshake. It keeps the global busywait freeze and adds flush with NOP bubble insertion, a skid entry so in_ready is registered, and saturating stall/flush counters for performance analysis.

---
 rtl/if_id_elastic_stage_pkg.sv | 31 +++
 rtl/if_id_elastic_stage_if.sv | 40 ++++
 rtl/if_id_elastic_stage_sat_counter.sv | 36 +++
 rtl/if_id_elastic_stage.sv | 157 +++++++++++++++
 tb/tb_if_id_elastic_stage.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/if_id_elastic_stage_pkg.sv
// ---------------------------------------------------------------------------
// if_id_elastic_stage_pkg
// Shared definitions for the IF/ID elastic stage.
//
// Contents:
//    DEFAULT_PC_W / DEFAULT_INSTR_W / DEFAULT_CNT_W : default payload and counter widths
//    RV32I_NOP                                      : canonical NOP (addi x0,x0,0)
//    stage_state_e                                  : EMPTY/ONE/FULL (encoding equals occupancy)
//    readyForState()                                : in_ready value implied by a state
// ---------------------------------------------------------------------------
package if_id_elastic_stage_pkg;

   localparam int DEFAULT_PC_W    = 32;
   localparam int DEFAULT_INSTR_W = 32;
   localparam int DEFAULT_CNT_W   = 16;

   localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

   // The numeric encoding doubles as the occupancy count, so keep it 0/1/2.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } stage_state_e;

   // The stage can take another word in every state except FULL.
   function automatic logic readyForState(input stage_state_e state);
      return (state != FULL);
   endfunction

endpackage

// File: rtl/if_id_elastic_stage_if.sv
// ---------------------------------------------------------------------------
// if_id_elastic_stage_if
// Fetch-side and decode-side valid/ready buses of the IF/ID elastic stage.
//
// Signals:
//    in_valid / in_ready / in_pc / in_instr     : fetch -> stage
//    out_valid / out_ready / out_pc / out_instr : stage -> decode
//
// Modports:
//    slave  : the stage itself
//    master : the surrounding pipeline (fetch and decode)
// ---------------------------------------------------------------------------
interface if_id_elastic_stage_if
   import if_id_elastic_stage_pkg::*;
#(
   parameter int PC_W    = DEFAULT_PC_W,
   parameter int INSTR_W = DEFAULT_INSTR_W
) ();

   logic               in_valid;
   logic               in_ready;
   logic [PC_W-1:0]    in_pc;
   logic [INSTR_W-1:0] in_instr;

   logic               out_valid;
   logic               out_ready;
   logic [PC_W-1:0]    out_pc;
   logic [INSTR_W-1:0] out_instr;

   modport slave (
      input  in_valid, in_pc, in_instr, out_ready,
      output in_ready, out_valid, out_pc, out_instr
   );

   modport master (
      output in_valid, in_pc, in_instr, out_ready,
      input  in_ready, out_valid, out_pc, out_instr
   );

endinterface

// File: rtl/if_id_elastic_stage_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//
// Ports:
//    clk     : rising-edge clock
//    rst     : synchronous active-high reset (clears the count)
//    clear_i : synchronous clear
//    inc_i   : count up by one this cycle
//    count_o : current count
// ---------------------------------------------------------------------------
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q;

   // Reset and clear win over increment; once all-ones is reached the value
   // is frozen so performance numbers never silently wrap back to small values.
   always_ff @(posedge clk) begin
      if (rst || clear_i) begin
         count_q <= '0;
      end else if (inc_i && (count_q != '1)) begin
         count_q <= count_q + WIDTH'(1);
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/if_id_elastic_stage.sv
// ---------------------------------------------------------------------------
// if_id_elastic_stage
// Two-entry elastic IF/ID pipeline register carrying {pc, instr}.
// A head entry drives the decode side; a skid entry absorbs the one word that
// can arrive after decode stalls, which lets in_ready come straight from a flop.
//
// Ports:
//    clk, rst   : clock and synchronous active-high reset
//    busywait   : global memory stall, freezes the stage and hides its outputs
//    flush      : redirect, drops held entries and the word offered this cycle
//    bus        : fetch/decode handshake buses (slave modport)
//    occupancy  : number of held entries (0..2)
//    stall_cnt  : saturating count of stalled cycles
//    flush_cnt  : saturating count of flush cycles
// ---------------------------------------------------------------------------
module if_id_elastic_stage
   import if_id_elastic_stage_pkg::*;
#(
   parameter int                 PC_W      = DEFAULT_PC_W,
   parameter int                 INSTR_W   = DEFAULT_INSTR_W,
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(RV32I_NOP),
   parameter int                 CNT_W     = DEFAULT_CNT_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  busywait,
   input  logic                  flush,
   if_id_elastic_stage_if.slave  bus,
   output logic [1:0]            occupancy,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt
);

   stage_state_e       state_q,     state_d;
   logic [PC_W-1:0]    headPc_q,    headPc_d;
   logic [INSTR_W-1:0] headInstr_q, headInstr_d;
   logic [PC_W-1:0]    skidPc_q,    skidPc_d;
   logic [INSTR_W-1:0] skidInstr_q, skidInstr_d;
   logic               inReady_q,   inReady_d;

   logic headValid;
   logic outValid;
   logic inReady;
   logic inFire;
   logic outFire;

   // Handshake qualification. busywait masks both sides, so while it is high
   // neither fire signal can be asserted and the state machine simply holds.
   // flush keeps in_ready as registered but refuses the word that cycle.
   assign headValid = (state_q != EMPTY);
   assign outValid  = headValid & ~busywait;
   assign inReady   = inReady_q & ~busywait;
   assign inFire    = bus.in_valid & inReady & ~flush;
   assign outFire   = outValid & bus.out_ready;

   assign bus.in_ready  = inReady;
   assign bus.out_valid = outValid;
   assign bus.out_pc    = headPc_q;
   assign bus.out_instr = outValid ? headInstr_q : NOP_INSTR;
   assign occupancy     = state_q;

   // Next-state logic for the storage FSM. Flush empties the stage and zeroes
   // the visible PC; otherwise words move input -> head, input -> skid, or
   // skid -> head so that order in always matches order out. in_ready is
   // precomputed from the next state so it never depends on out_ready
   // combinationally.
   always_comb begin
      state_d     = state_q;
      headPc_d    = headPc_q;
      headInstr_d = headInstr_q;
      skidPc_d    = skidPc_q;
      skidInstr_d = skidInstr_q;

      if (flush) begin
         state_d     = EMPTY;
         headPc_d    = '0;
         headInstr_d = NOP_INSTR;
      end else begin
         case (state_q)
            EMPTY: begin
               if (inFire) begin
                  state_d     = ONE;
                  headPc_d    = bus.in_pc;
                  headInstr_d = bus.in_instr;
               end
            end
            ONE: begin
               if (inFire && outFire) begin
                  headPc_d    = bus.in_pc;
                  headInstr_d = bus.in_instr;
               end else if (inFire) begin
                  state_d     = FULL;
                  skidPc_d    = bus.in_pc;
                  skidInstr_d = bus.in_instr;
               end else if (outFire) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (outFire) begin
                  state_d     = ONE;
                  headPc_d    = skidPc_q;
                  headInstr_d = skidInstr_q;
               end
            end
            default: begin
               state_d = EMPTY;
            end
         endcase
      end

      inReady_d = readyForState(state_d);
   end

   // Stage registers. Reset returns to an empty stage that is ready to accept
   // and shows PC 0 with a NOP on the decode side.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= EMPTY;
         headPc_q    <= '0;
         headInstr_q <= NOP_INSTR;
         skidPc_q    <= '0;
         skidInstr_q <= NOP_INSTR;
         inReady_q   <= 1'b1;
      end else begin
         state_q     <= state_d;
         headPc_q    <= headPc_d;
         headInstr_q <= headInstr_d;
         skidPc_q    <= skidPc_d;
         skidInstr_q <= skidInstr_d;
         inReady_q   <= inReady_d;
      end
   end

   // A stalled cycle is one where memory is busy or decode refuses a valid word.
   sat_counter #(
      .WIDTH (CNT_W)
   ) stallCounter (
      .clk     (clk),
      .rst     (rst),
      .clear_i (1'b0),
      .inc_i   (busywait | (outValid & ~bus.out_ready)),
      .count_o (stall_cnt)
   );

   // Every flush cycle counts, including flushes of an already empty stage.
   sat_counter #(
      .WIDTH (CNT_W)
   ) flushCounter (
      .clk     (clk),
      .rst     (rst),
      .clear_i (1'b0),
      .inc_i   (flush),
      .count_o (flush_cnt)
   );

endmodule

// File: tb/tb_if_id_elastic_stage.sv
// ---------------------------------------------------------------------------
// tb_if_id_elastic_stage
// Directed self-checking bench for if_id_elastic_stage, built with 4-bit
// counters so that stall counter saturation is reachable in a few cycles.
// ---------------------------------------------------------------------------
module tb_if_id_elastic_stage;
   import if_id_elastic_stage_pkg::*;

   localparam int          PC_W    = 32;
   localparam int          INSTR_W = 32;
   localparam int          CNT_W   = 4;
   localparam logic [31:0] NOP     = 32'h0000_0013;
   localparam logic        H       = 1'b1;
   localparam logic        L       = 1'b0;

   logic             clk = 1'b0;
   logic             rst;
   logic             busywait;
   logic             flush;
   logic [1:0]       occupancy;
   logic [CNT_W-1:0] stallCnt;
   logic [CNT_W-1:0] flushCnt;

   int assertCount = 0;
   int failCount   = 0;

   if_id_elastic_stage_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

   if_id_elastic_stage #(
      .PC_W      (PC_W),
      .INSTR_W   (INSTR_W),
      .NOP_INSTR (NOP),
      .CNT_W     (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .busywait  (busywait),
      .flush     (flush),
      .bus       (bus),
      .occupancy (occupancy),
      .stall_cnt (stallCnt),
      .flush_cnt (flushCnt)
   );

   // Free-running 10-time-unit clock.
   always #5 clk = ~clk;

   // Instruction word tied to its PC so a wrong head entry is always visible.
   function automatic logic [31:0] instrOf(input logic [31:0] pc);
      return 32'hA500_0000 | pc;
   endfunction

   // Step to one time unit after the next rising edge.
   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Drive every input, then let combinational outputs settle.
   task automatic applyStimulus(input logic r, input logic bw, input logic fl,
                                input logic iv, input logic [31:0] pc,
                                input logic ordy);
      rst           = r;
      busywait      = bw;
      flush         = fl;
      bus.in_valid  = iv;
      bus.in_pc     = pc;
      bus.in_instr  = instrOf(pc);
      bus.out_ready = ordy;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkState(input string tag, input logic expValid,
                             input logic expReady, input logic [31:0] expPc,
                             input logic [31:0] expInstr, input logic [1:0] expOcc);
      checkOutput({tag, ".out_valid"}, 32'(bus.out_valid), 32'(expValid));
      checkOutput({tag, ".in_ready"},  32'(bus.in_ready),  32'(expReady));
      checkOutput({tag, ".out_pc"},    bus.out_pc,         expPc);
      checkOutput({tag, ".out_instr"}, bus.out_instr,      expInstr);
      checkOutput({tag, ".occupancy"}, 32'(occupancy),     32'(expOcc));
   endtask

   task automatic checkCounters(input string tag, input int expStall, input int expFlush);
      checkOutput({tag, ".stall_cnt"}, 32'(stallCnt), 32'(expStall));
      checkOutput({tag, ".flush_cnt"}, 32'(flushCnt), 32'(expFlush));
   endtask

   // Directed sequence; expected values are worked out by hand in the comments.
   initial begin
      // Reset held for two edges.
      applyStimulus(H, L, L, L, 32'h0, L);
      nextCycle();
      nextCycle();
      checkState("reset", L, H, 32'h0, NOP, 2'd0);
      checkCounters("reset", 0, 0);

      // Streaming with decode always ready: one-cycle latency, occupancy 1.
      applyStimulus(L, L, L, H, 32'h00, H);
      nextCycle();
      checkState("stream.pc00", H, H, 32'h00, instrOf(32'h00), 2'd1);
      applyStimulus(L, L, L, H, 32'h04, H);
      nextCycle();
      checkState("stream.pc04", H, H, 32'h04, instrOf(32'h04), 2'd1);
      applyStimulus(L, L, L, H, 32'h08, H);
      nextCycle();
      checkState("stream.pc08", H, H, 32'h08, instrOf(32'h08), 2'd1);
      applyStimulus(L, L, L, L, 32'h00, H);
      nextCycle();
      checkState("stream.empty", L, H, 32'h08, NOP, 2'd0);
      checkCounters("stream", 0, 0);

      // Decode stalled: 0x10 lands in head, 0x14 in skid, in_ready drops.
      applyStimulus(L, L, L, H, 32'h10, L);
      nextCycle();
      checkState("fill.one", H, H, 32'h10, instrOf(32'h10), 2'd1);
      applyStimulus(L, L, L, H, 32'h14, L);
      nextCycle();
      checkState("fill.full", H, L, 32'h10, instrOf(32'h10), 2'd2);
      checkCounters("fill", 1, 0);

      // busywait for three cycles hides the FULL stage even with decode ready.
      applyStimulus(L, H, L, L, 32'h00, H);
      checkState("busy.freeze", L, L, 32'h10, NOP, 2'd2);
      nextCycle();
      nextCycle();
      nextCycle();
      checkCounters("busy", 4, 0);
      applyStimulus(L, L, L, L, 32'h00, L);
      checkState("busy.release", H, L, 32'h10, instrOf(32'h10), 2'd2);

      // Drain in order: 0x10 leaves, 0x14 moves up, then empty.
      applyStimulus(L, L, L, L, 32'h00, H);
      nextCycle();
      checkState("drain.pc14", H, H, 32'h14, instrOf(32'h14), 2'd1);
      nextCycle();
      checkState("drain.empty", L, H, 32'h14, NOP, 2'd0);
      checkCounters("drain", 4, 0);

      // Flush while FULL with 0x40 offered: everything dropped.
      applyStimulus(L, L, L, H, 32'h20, L);
      nextCycle();
      applyStimulus(L, L, L, H, 32'h24, L);
      nextCycle();
      checkState("flush.full", H, L, 32'h20, instrOf(32'h20), 2'd2);
      applyStimulus(L, L, H, H, 32'h40, L);
      nextCycle();
      applyStimulus(L, L, L, L, 32'h00, H);
      checkState("flush.empty", L, H, 32'h00, NOP, 2'd0);
      checkCounters("flush", 6, 1);
      nextCycle();
      checkState("flush.no40", L, H, 32'h00, NOP, 2'd0);

      // flush and busywait together: flush wins.
      applyStimulus(L, L, L, H, 32'h50, L);
      nextCycle();
      checkState("fb.one", H, H, 32'h50, instrOf(32'h50), 2'd1);
      applyStimulus(L, H, H, L, 32'h00, L);
      nextCycle();
      applyStimulus(L, L, L, L, 32'h00, L);
      checkState("fb.empty", L, H, 32'h00, NOP, 2'd0);
      checkCounters("fb", 7, 2);

      // Flush of an empty stage still counts.
      applyStimulus(L, L, H, L, 32'h00, L);
      nextCycle();
      applyStimulus(L, L, L, L, 32'h00, L);
      checkCounters("flush.idle", 7, 3);

      // Flush with decode ready: head is still offered before the edge.
      applyStimulus(L, L, L, H, 32'h58, H);
      nextCycle();
      applyStimulus(L, L, H, H, 32'h5C, H);
      checkOutput("flushfire.out_valid", 32'(bus.out_valid), 32'h1);
      checkOutput("flushfire.out_pc", bus.out_pc, 32'h58);
      nextCycle();
      applyStimulus(L, L, L, L, 32'h00, H);
      checkState("flushfire.empty", L, H, 32'h00, NOP, 2'd0);
      checkCounters("flushfire", 7, 4);

      // Saturation: 7 + 8 stalled edges = 15, then it must stay at 15.
      applyStimulus(L, L, L, H, 32'h60, L);
      nextCycle();
      applyStimulus(L, L, L, L, 32'h00, L);
      checkCounters("sat.start", 7, 4);
      repeat (8) nextCycle();
      checkCounters("sat.reach", 15, 4);
      repeat (12) nextCycle();
      checkCounters("sat.hold", 15, 4);
      checkState("sat.one", H, H, 32'h60, instrOf(32'h60), 2'd1);

      // Reset in the middle of traffic.
      applyStimulus(H, L, L, H, 32'h70, H);
      nextCycle();
      checkState("midreset", L, H, 32'h00, NOP, 2'd0);
      checkCounters("midreset", 0, 0);
      applyStimulus(L, L, L, L, 32'h00, L);
      nextCycle();
      checkState("postreset", L, H, 32'h00, NOP, 2'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
